plot_arbiter: RTL and testbench

//  Sink side of the sprite plot interface: accepts pixel streams (plot/x/y/colour/done) from up to N_REQ

---
 rtl/game_pkg.sv | 14 +
 rtl/rr_picker.sv | 30 +++
 rtl/plot_arbiter.sv | 119 +++++++++++
 tb/tb_plot_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared screen geometry, pixel field widths and plot arbiter state encoding
package game_pkg;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COL_W    = 3;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} arb_state_t;

    function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner search starting at ptr and wrapping upward
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);
    int c;

    // scan from farthest to nearest so the nearest set request after ptr is the last one kept
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        c      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N_REQ;
            if (req[c]) begin
                onehot    = '0;
                onehot[c] = 1'b1;
                idx       = PTR_W'(c);
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin owner of the VGA pixel port among sprite plot FSMs, with watchdog.
// Optional PLOT_CLIP_EN suppresses writes of off-screen pixels.
module plot_arbiter
    import game_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       plot,
    input  logic [N_REQ-1:0]       done,
    input  logic [N_REQ*X_W-1:0]   x_in,
    input  logic [N_REQ*Y_W-1:0]   y_in,
    input  logic [N_REQ*COL_W-1:0] colour_in,
    output logic [N_REQ-1:0]       grant,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COL_W-1:0]       vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t       state, state_nx;
    logic [PTR_W-1:0] owner, ptr, win_idx;
    logic [N_REQ-1:0] win_oh, owner_oh;
    logic             win_vld;
    logic [CNT_W-1:0] wd;
    logic [X_W-1:0]   own_x;
    logic [Y_W-1:0]   own_y;
    logic [COL_W-1:0] own_col;
    logic             own_plot, own_done, wd_hit, pix_ok;

    rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .valid  (win_vld)
    );

    // select the current owner's pixel stream and decide whether it may be written
    always_comb begin
        own_x    = x_in[owner*X_W +: X_W];
        own_y    = y_in[owner*Y_W +: Y_W];
        own_col  = colour_in[owner*COL_W +: COL_W];
        own_plot = plot[owner];
        own_done = done[owner];
        wd_hit   = wd == CNT_W'(TIMEOUT_CYC);
`ifdef PLOT_CLIP_EN
        pix_ok   = on_screen(own_x, own_y);
`else
        pix_ok   = 1'b1;
`endif
    end

    // next state, grant visibility, busy and watchdog pulse; done wins over a same-cycle timeout
    always_comb begin
        state_nx    = state;
        grant       = '0;
        busy        = state != S_IDLE;
        timeout_err = 1'b0;
        case (state)
            S_IDLE:    state_nx = win_vld ? S_GRANT : S_IDLE;
            S_GRANT: begin
                grant = owner_oh;
                if (own_done) state_nx = S_RELEASE;
                else if (wd_hit) begin
                    state_nx    = S_RELEASE;
                    timeout_err = 1'b1;
                end
            end
            S_RELEASE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // state, ownership, round-robin pointer and watchdog registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= '0;
            owner_oh <= '0;
            ptr      <= '0;
            wd       <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && win_vld) begin
                owner    <= win_idx;
                owner_oh <= win_oh;
                ptr      <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                wd       <= '0;
            end else if (state == S_GRANT) begin
                wd <= wd + 1'b1;
            end
        end
    end

    // one-cycle registered pixel path; coordinates only move when the owner presents a pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= (state == S_GRANT) && own_plot && pix_ok;
            if (state == S_GRANT && own_plot) begin
                vga_x      <= own_x;
                vga_y      <= own_y;
                vga_colour <= own_col;
            end
        end
    end
endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed scenarios plus random traffic against a transaction-level reference model
module tb_plot_arbiter;
    import game_pkg::*;

    localparam int N  = 4;
    localparam int TO = 1023;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0, plot = '0, done = '0;
    logic [N*9-1:0] x_in = '0;
    logic [N*8-1:0] y_in = '0;
    logic [N*3-1:0] colour_in = '0;
    logic [N-1:0]   grant;
    logic [8:0]     vga_x;
    logic [7:0]     vga_y;
    logic [2:0]     vga_colour;
    logic           vga_plot, busy, timeout_err;

    plot_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO), .CNT_W(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .plot        (plot),
        .done        (done),
        .x_in        (x_in),
        .y_in        (y_in),
        .colour_in   (colour_in),
        .grant       (grant),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit mon_en = 0;
    int plot_cnt = 0, to_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    // reference model: who owns the port, whether we sit in the gap, how long the grant has lasted
    int m_owner = -1, m_ptr = 0, m_wd = 0;
    bit m_gap = 0, e_plot = 0;
    logic [8:0] e_x = '0;
    logic [7:0] e_y = '0;
    logic [2:0] e_c = '0;

    function automatic bit visible(input logic [8:0] x, input logic [7:0] y);
`ifdef PLOT_CLIP_EN
        return x < 320 && y < 240;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_wd = 0; m_gap = 0;
            e_plot = 0; e_x = '0; e_y = '0; e_c = '0;
        end else begin
            e_plot = 0;
            if (m_owner >= 0 && plot[m_owner]) begin
                e_plot = visible(x_in[m_owner*9 +: 9], y_in[m_owner*8 +: 8]);
                e_x = x_in[m_owner*9 +: 9];
                e_y = y_in[m_owner*8 +: 8];
                e_c = colour_in[m_owner*3 +: 3];
            end
            if (m_gap) m_gap = 0;
            else if (m_owner >= 0) begin
                if (done[m_owner] || m_wd == TO) begin m_owner = -1; m_gap = 1; end
                else m_wd++;
            end else if (req != 0) begin
                for (int k = 0; k < N; k++)
                    if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                m_ptr = (m_owner + 1) % N;
                m_wd = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("grant", grant, m_owner >= 0 ? 32'(1 << m_owner) : 0);
            check("busy", busy, m_owner >= 0 || m_gap);
            check("vga_plot", vga_plot, e_plot);
            check("vga_x", vga_x, e_x);
            check("vga_y", vga_y, e_y);
            check("vga_colour", vga_colour, e_c);
            check("timeout_err", timeout_err, m_owner >= 0 && m_wd == TO && !done[m_owner]);
            if (vga_plot) plot_cnt++;
            if (timeout_err) to_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int base, n, prev, idx, k;
        repeat (2) tick();
        reset = 1'b0;
        mon_en = 1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);

        // 1: single requester streams 560 pixels
        do_reset();
        req = 4'b0001;
        tick();
        check("t1_grant", grant, 4'b0001);
        req = '0;
        base = plot_cnt;
        for (int i = 0; i < 560; i++) begin
            plot = 4'b0001;
            x_in[8:0] = 9'(i % 320);
            y_in[7:0] = 8'(i % 240);
            colour_in[2:0] = 3'(i);
            tick();
        end
        plot = '0; done = 4'b0001;
        tick();
        done = '0;
        repeat (2) tick();
        check("t1_plots", plot_cnt - base, 560);

        // 2: req0 and req2 together
        do_reset();
        req = 4'b0101;
        tick();
        check("t2_first", grant, 4'b0001);
        req = 4'b0100; done = 4'b0001;
        tick();
        done = '0;
        check("t2_gap", grant, 0);
        check("t2_gap_busy", busy, 1);
        repeat (2) tick();
        check("t2_second", grant, 4'b0100);
        req = '0; done = 4'b0100;
        tick();
        done = '0;
        repeat (2) tick();

        // 3: everyone requesting forever
        do_reset();
        req = '1;
        prev = -1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (grant == 0 && n < 8) begin tick(); n++; end
            check("t3_granted", n < 8, 1);
            idx = oh_idx(grant);
            check("t3_order", idx, g % 4);
            check("t3_no_repeat", idx != prev, 1);
            prev = idx;
            done = grant;
            tick();
            done = '0;
        end
        req = '0;
        repeat (4) tick();

        // 4: stuck owner revoked by watchdog
        do_reset();
        req = 4'b0011;
        tick();
        base = to_cnt;
        n = 0; k = 0;
        while (k < 1100) begin
            if (grant[0]) n++;
            if (timeout_err) break;
            tick();
            k++;
        end
        check("t4_timeout_seen", timeout_err, 1);
        check("t4_grant_len", n, TO + 1);
        tick();
        check("t4_pulse_end", timeout_err, 0);
        check("t4_release", grant, 0);
        repeat (2) tick();
        check("t4_next", grant, 4'b0010);
        check("t4_pulses", to_cnt - base, 1);
        req = '0; done = 4'b0010;
        tick();
        done = '0;
        repeat (2) tick();

        // 5: reset mid-grant
        do_reset();
        req = 4'b0010;
        tick();
        check("t5_grant", grant, 4'b0010);
        req = '0; plot = 4'b0010; x_in[17:9] = 9'd100;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("t5_rst_grant", grant, 0);
        check("t5_rst_plot", vga_plot, 0);
        check("t5_rst_x", vga_x, 0);
        check("t5_rst_busy", busy, 0);
        reset = 1'b0; plot = '0; req = 4'b1010;
        tick();
        check("t5_regrant", grant, 4'b0010);
        req = '0; done = 4'b0010;
        tick();
        done = '0;
        repeat (2) tick();

        // 6: edge-of-screen pixels
        do_reset();
        req = 4'b0001;
        tick();
        req = '0;
        base = plot_cnt;
        plot = 4'b0001;
        x_in[8:0] = 9'd319; y_in[7:0] = 8'd10; tick();
        x_in[8:0] = 9'd320; y_in[7:0] = 8'd10; tick();
        x_in[8:0] = 9'd5;   y_in[7:0] = 8'd240; tick();
        plot = '0; done = 4'b0001;
        tick();
        done = '0;
        tick();
`ifdef PLOT_CLIP_EN
        check("t6_clip", plot_cnt - base, 1);
`else
        check("t6_clip", plot_cnt - base, 3);
`endif

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req = N'($urandom);
            plot = N'($urandom);
            for (int j = 0; j < N; j++) done[j] = ($urandom_range(15) == 0);
            x_in = 36'({$urandom, $urandom});
            y_in = $urandom;
            colour_in = 12'($urandom);
            if ($urandom_range(499) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        req = '0; plot = '0; done = '0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
